// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with selectable registered-read or first-word-fall-through
// output, registered status flags derived from the next occupancy, and sticky
// overflow/underflow indicators.
module sync_fifo_flex #(
    parameter int DATA_LEN      = 32,
    parameter int ADDR_LEN      = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (2 ** ADDR_LEN) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write_en,
    input  logic [DATA_LEN-1:0] wdata_i,
    input  logic                read_en,
    input  logic                err_clr_i,
    output logic [DATA_LEN-1:0] rdata_o,
    output logic                rempty_o,
    output logic                wfull_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic [ADDR_LEN:0]   count_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int              DEPTH    = 2 ** ADDR_LEN;
    localparam logic [ADDR_LEN:0] DEPTH_C  = (ADDR_LEN + 1)'(DEPTH);
    localparam logic [ADDR_LEN:0] AFULL_C  = (ADDR_LEN + 1)'(AFULL_THRESH);
    localparam logic [ADDR_LEN:0] AEMPTY_C = (ADDR_LEN + 1)'(AEMPTY_THRESH);

    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [ADDR_LEN-1:0] wr_ptr;
    logic [ADDR_LEN-1:0] rd_ptr;
    logic [ADDR_LEN:0]   count_nxt;
    logic                push_ok;
    logic                pop_ok;

    // Acceptance is judged on the registered flags, so a full FIFO drops a
    // push even when a pop frees a slot in the same cycle (and vice versa).
    assign push_ok = write_en && !wfull_o;
    assign pop_ok  = read_en && !rempty_o;

    // Next occupancy; flags are registered from this so they line up with count_o.
    always_comb begin
        count_nxt = count_o;
        if (push_ok && !pop_ok) begin
            count_nxt = count_o + (ADDR_LEN + 1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count_o - (ADDR_LEN + 1)'(1);
        end
    end

    // Storage write; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_o        <= '0;
            rempty_o       <= 1'b1;
            wfull_o        <= 1'b0;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_LEN'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_LEN'(1);
            end
            count_o        <= count_nxt;
            rempty_o       <= (count_nxt == '0);
            wfull_o        <= (count_nxt == DEPTH_C);
            almost_full_o  <= (count_nxt >= AFULL_C);
            almost_empty_o <= (count_nxt <= AEMPTY_C);
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= (overflow_o && !err_clr_i) || (write_en && wfull_o);
            underflow_o <= (underflow_o && !err_clr_i) || (read_en && rempty_o);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown combinationally; zero while empty.
            always_comb begin
                rdata_o = '0;
                if (!rempty_o) begin
                    rdata_o = mem[rd_ptr];
                end
            end
        end else begin : g_reg_read
            // Head word captured on an accepted pop and held until the next one.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_o <= '0;
                end else if (pop_ok) begin
                    rdata_o <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: doc/sync_fifo_flex.md
SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 Parameter DATA_LEN, default 32, word width in bits.
REQ-002 Parameter ADDR_LEN, default 4, pointer width; DEPTH = 2^ADDR_LEN entries.
REQ-003 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AFULL_THRESH, default DEPTH-2, almost-full level; legal range 1..DEPTH.
REQ-005 Parameter AEMPTY_THRESH, default 2, almost-empty level; legal range 0..DEPTH-1.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-008 write_en  input  1  push request.
REQ-009 wdata_i  input  DATA_LEN  push data.
REQ-010 read_en  input  1  pop request.
REQ-011 err_clr_i  input  1  clears sticky error flags.
REQ-012 rdata_o  output  DATA_LEN  read data.
REQ-013 rempty_o  output  1  FIFO empty.
REQ-014 wfull_o  output  1  FIFO full.
REQ-015 almost_full_o  output  1  count >= AFULL_THRESH.
REQ-016 almost_empty_o  output  1  count <= AEMPTY_THRESH.
REQ-017 count_o  output  ADDR_LEN+1  current occupancy, 0..DEPTH.
REQ-018 overflow_o  output  1  sticky: a push was dropped.
REQ-019 underflow_o  output  1  sticky: a pop was refused.

Function
REQ-020 Push accepted when write_en=1 and wfull_o=0; wdata_i is stored at the write pointer, and the write pointer increments mod DEPTH.
REQ-021 Pop accepted when read_en=1 and rempty_o=0; the read pointer increments mod DEPTH.
REQ-022 Full FIFO: write_en is dropped even if a pop is accepted in the same cycle; overflow_o sets the next cycle.
REQ-023 Empty FIFO: read_en is refused even if a push is accepted in the same cycle; underflow_o sets the next cycle.
REQ-024 Simultaneous accepted push and pop: count_o unchanged, both pointers advance.
REQ-025 count_o updates the cycle after an accepted push or pop, by +1 or -1; it never exceeds DEPTH and never wraps below 0.
REQ-026 rempty_o, wfull_o, almost_full_o and almost_empty_o are registered and consistent with count_o in the same cycle: rempty_o = (count_o == 0), wfull_o = (count_o == DEPTH).
REQ-027 FWFT=0: on an accepted pop, rdata_o presents the head word one cycle later and holds it until the next accepted pop.
REQ-028 FWFT=1: rdata_o continuously presents the head word while rempty_o=0 and is 0 while rempty_o=1.
REQ-029 FWFT=1: a word pushed into an empty FIFO is visible on rdata_o, with rempty_o=0, one cycle after the push.
REQ-030 Pointer wrap: ordering is preserved across the DEPTH-1 -> 0 boundary.
REQ-031 Sticky flags hold until err_clr_i=1 or rst=1; if clear and a new error coincide, the set wins.
REQ-032 Words are output in strict write order, with no loss or duplication for accepted operations.

Reset
REQ-033 While rst=1 at a clock edge: pointers=0, count_o=0, rempty_o=1, wfull_o=0, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0, rdata_o=0.
REQ-034 write_en and read_en are ignored in any cycle with rst=1; storage contents need not be cleared.
REQ-035 Reset asserted mid-operation discards all stored words; the first post-reset pop returns the first post-reset push.

Verification
REQ-036 Fill: DEPTH=16, FWFT=0, 16 pushes of 0..15 -> wfull_o=1, count_o=16, almost_full_o=1 from count 14; a 17th push (0xAA) sets overflow_o and is never read back.
REQ-037 Drain: from full, 16 pops -> rdata_o sequence 0..15 each one cycle after its pop; rempty_o=1; a 17th pop sets underflow_o and rdata_o holds 15.
REQ-038 FWFT=1: single push 0xDEADBEEF into empty -> next cycle rempty_o=0 and rdata_o=0xDEADBEEF with no read_en; a pop makes rempty_o=1 and rdata_o=0.
REQ-039 Simultaneous: at count 8, push and pop together for 40 cycles -> count_o stays 8, data order preserved across pointer wrap.
REQ-040 Reset mid-stream: push 5 words, assert rst one cycle with write_en=1 -> count_o=0, flags at reset values; push 0x1 then pop -> 0x1.
REQ-041 Random: 200 cycles of random write_en/read_en/data against a scoreboard model -> zero mismatches; err_clr_i clears both sticky flags.
